// File: rtl/axil_pkg.sv
// axil_pkg
//   Shared AXI4-lite definitions for the register slave.
//   - AXIL_RESP_OKAY / AXIL_RESP_SLVERR : BRESP/RRESP encodings
//   - clog2()                           : ceiling log2 for parameter math
package axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axil_reg_slave_wr_join.sv
// axil_reg_slave_wr_join
//   Accepts AXI-lite write address and write data independently, holds at
//   most one of each, and joins them into a single commit strobe once both
//   are available and the B response slot can take the response.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   awaddr/awvalid/awready   write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   b_free                   B slot can accept a new response this edge
//   commit                   one-cycle strobe: a write completes this edge
//   commit_idx/data/strb     word index, data and byte strobes of the write
//   commit_in_range          index < REG_COUNT (upper address bits all zero)
module axil_reg_slave_wr_join
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int REG_COUNT  = 16,
  localparam int ADDR_LSB  = clog2(STRB_WIDTH),
  localparam int IDX_WIDTH = clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  b_free,
  output logic                  commit,
  output logic [IDX_WIDTH-1:0]  commit_idx,
  output logic [DATA_WIDTH-1:0] commit_data,
  output logic [STRB_WIDTH-1:0] commit_strb,
  output logic                  commit_in_range
);

  logic                  aw_held_reg, aw_held_next;
  logic [IDX_WIDTH-1:0]  aw_idx_reg, aw_idx_next;
  logic                  aw_in_range_reg, aw_in_range_next;
  logic                  w_held_reg, w_held_next;
  logic [DATA_WIDTH-1:0] w_data_reg, w_data_next;
  logic [STRB_WIDTH-1:0] w_strb_reg, w_strb_next;

  logic                  aw_hs;
  logic                  w_hs;
  logic [IDX_WIDTH-1:0]  aw_idx_in;
  logic                  aw_in_range_in;

  // Readies are forced low while reset is asserted, not just after it.
  assign awready = rst && !aw_held_reg;
  assign wready  = rst && !w_held_reg;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Decode the address on entry so only index + range flag are held.
  assign aw_idx_in      = awaddr[ADDR_LSB +: IDX_WIDTH];
  assign aw_in_range_in = (awaddr >> (ADDR_LSB + IDX_WIDTH)) == '0;

  // A held beat takes priority over a new one; the ready of a held channel
  // is low, so there can never be both.
  assign commit          = (aw_held_reg || aw_hs) && (w_held_reg || w_hs) && b_free;
  assign commit_idx      = aw_held_reg ? aw_idx_reg      : aw_idx_in;
  assign commit_in_range = aw_held_reg ? aw_in_range_reg : aw_in_range_in;
  assign commit_data     = w_held_reg  ? w_data_reg      : wdata;
  assign commit_strb     = w_held_reg  ? w_strb_reg      : wstrb;

  always_comb begin
    aw_held_next     = aw_held_reg;
    aw_idx_next      = aw_idx_reg;
    aw_in_range_next = aw_in_range_reg;
    w_held_next      = w_held_reg;
    w_data_next      = w_data_reg;
    w_strb_next      = w_strb_reg;
    if (commit) begin
      aw_held_next = 1'b0;
      w_held_next  = 1'b0;
    end else begin
      // Covers both a lone beat and a joined pair blocked by a busy B slot.
      if (aw_hs) begin
        aw_held_next     = 1'b1;
        aw_idx_next      = aw_idx_in;
        aw_in_range_next = aw_in_range_in;
      end
      if (w_hs) begin
        w_held_next = 1'b1;
        w_data_next = wdata;
        w_strb_next = wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held_reg     <= 1'b0;
      aw_idx_reg      <= '0;
      aw_in_range_reg <= 1'b0;
      w_held_reg      <= 1'b0;
      w_data_reg      <= '0;
      w_strb_reg      <= '0;
    end else begin
      aw_held_reg     <= aw_held_next;
      aw_idx_reg      <= aw_idx_next;
      aw_in_range_reg <= aw_in_range_next;
      w_held_reg      <= w_held_next;
      w_data_reg      <= w_data_next;
      w_strb_reg      <= w_strb_next;
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// axil_reg_slave
//   AXI4-lite slave backed by REG_COUNT read/write registers of DATA_WIDTH
//   bits. Writes are byte-strobed; reads return registered data at full
//   throughput. All register contents are exported on reg_q.
// Configuration macro:
//   AXIL_REG_SLAVE_ERR_EN  out-of-range accesses answer SLVERR instead of
//                          OKAY (data effects identical: write dropped,
//                          read data zero).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   s_axil_aw*      write address channel (awprot ignored)
//   s_axil_w*       write data channel
//   s_axil_b*       write response channel
//   s_axil_ar*      read address channel (arprot ignored)
//   s_axil_r*       read data channel
//   reg_q           register i at [i*DATA_WIDTH +: DATA_WIDTH]
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int REG_COUNT  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [DATA_WIDTH-1:0]           s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_q
);

  localparam int ADDR_LSB  = clog2(STRB_WIDTH);
  localparam int IDX_WIDTH = clog2(REG_COUNT);

`ifdef AXIL_REG_SLAVE_ERR_EN
  localparam logic [1:0] OOR_RESP = AXIL_RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = AXIL_RESP_OKAY;
`endif

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("axil_reg_slave: DATA_WIDTH must be 32 or 64");
  end

  // Protection attributes carry no meaning for this register bank.
  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  // ---------------------------------------------------------------- write
  logic                  commit;
  logic [IDX_WIDTH-1:0]  commit_idx;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_WIDTH-1:0] commit_strb;
  logic                  commit_in_range;
  logic                  b_free;

  logic                  bvalid_reg, bvalid_next;
  logic [1:0]            bresp_reg, bresp_next;

  assign b_free = !bvalid_reg || s_axil_bready;

  axil_reg_slave_wr_join #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_wr_join (
    .clk             (clk),
    .rst             (rst),
    .awaddr          (s_axil_awaddr),
    .awvalid         (s_axil_awvalid),
    .awready         (s_axil_awready),
    .wdata           (s_axil_wdata),
    .wstrb           (s_axil_wstrb),
    .wvalid          (s_axil_wvalid),
    .wready          (s_axil_wready),
    .b_free          (b_free),
    .commit          (commit),
    .commit_idx      (commit_idx),
    .commit_data     (commit_data),
    .commit_strb     (commit_strb),
    .commit_in_range (commit_in_range)
  );

  always_comb begin
    bvalid_next = bvalid_reg;
    bresp_next  = bresp_reg;
    if (commit) begin
      bvalid_next = 1'b1;
      bresp_next  = commit_in_range ? AXIL_RESP_OKAY : OOR_RESP;
    end else if (s_axil_bready) begin
      bvalid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bvalid_reg <= 1'b0;
      bresp_reg  <= AXIL_RESP_OKAY;
    end else begin
      bvalid_reg <= bvalid_next;
      bresp_reg  <= bresp_next;
    end
  end

  assign s_axil_bvalid = bvalid_reg;
  assign s_axil_bresp  = bresp_reg;

  // ------------------------------------------------------- register bank
  // Each word is its own flop group so the asynchronous reset can clear the
  // whole bank; reg_q is the concatenation and also feeds the read mux.
  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
    localparam logic [IDX_WIDTH-1:0] MY_IDX = IDX_WIDTH'(gi);
    logic [DATA_WIDTH-1:0] word_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        word_reg <= '0;
      end else if (commit && commit_in_range && (commit_idx == MY_IDX)) begin
        for (int j = 0; j < STRB_WIDTH; j++) begin
          if (commit_strb[j]) begin
            word_reg[j*8 +: 8] <= commit_data[j*8 +: 8];
          end
        end
      end
    end

    assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
  end

  // ----------------------------------------------------------------- read
  logic                  ar_hs;
  logic [IDX_WIDTH-1:0]  ar_idx;
  logic                  ar_in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  rvalid_reg, rvalid_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [1:0]            rresp_reg, rresp_next;

  assign s_axil_arready = rst && (!rvalid_reg || s_axil_rready);
  assign ar_hs          = s_axil_arvalid && s_axil_arready;
  assign ar_idx         = s_axil_araddr[ADDR_LSB +: IDX_WIDTH];
  assign ar_in_range    = (s_axil_araddr >> (ADDR_LSB + IDX_WIDTH)) == '0;
  // reg_q is the pre-edge value, so a same-edge write is not visible here.
  assign rd_word        = reg_q[ar_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    rvalid_next = rvalid_reg;
    rdata_next  = rdata_reg;
    rresp_next  = rresp_reg;
    if (ar_hs) begin
      rvalid_next = 1'b1;
      rdata_next  = ar_in_range ? rd_word : '0;
      rresp_next  = ar_in_range ? AXIL_RESP_OKAY : OOR_RESP;
    end else if (s_axil_rready) begin
      rvalid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= AXIL_RESP_OKAY;
    end else begin
      rvalid_reg <= rvalid_next;
      rdata_reg  <= rdata_next;
      rresp_reg  <= rresp_next;
    end
  end

  assign s_axil_rvalid = rvalid_reg;
  assign s_axil_rdata  = rdata_reg;
  assign s_axil_rresp  = rresp_reg;

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave
//   Directed bench for axil_reg_slave (default parameters). Stimulus pushes
//   expected B / R responses into queues; a negedge monitor pops and compares
//   on every B/R handshake. Structural checks (readies, reg_q, latency) are
//   compared inline by the stimulus.
module tb_axil_reg_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int RC = 16;

`ifdef AXIL_REG_SLAVE_ERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [AW-1:0]  awaddr = '0;
  logic [2:0]     awprot = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [DW-1:0]  wdata = '0;
  logic [SW-1:0]  wstrb = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b1;
  logic [AW-1:0]  araddr = '0;
  logic [2:0]     arprot = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready = 1'b1;
  logic [RC*DW-1:0] reg_q;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];   // {rdata, rresp}

  logic [RC*DW-1:0] model_q = '0;

  always #5 clk = ~clk;

  axil_reg_slave dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .reg_q          (reg_q)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic chk_word(input string name, input int idx, input logic [31:0] exp);
    chk(name, {32'h0, reg_q[idx*DW +: DW]}, {32'h0, exp});
  endtask

  // Scoreboard monitor: one line per observed response.
  always @(negedge clk) begin
    if (rst && bvalid && bready) begin
      vectors++;
      if (exp_b.size() == 0) begin
        miscompares++;
        $display("FAIL b_unexpected: got bresp %b, expected no response", bresp);
      end else begin
        logic [1:0] e;
        e = exp_b.pop_front();
        if (bresp !== e) begin
          miscompares++;
          $display("FAIL b_resp: got %b, expected %b", bresp, e);
        end else begin
          $display("ok   b_resp: %b", bresp);
        end
      end
    end
    if (rst && rvalid && rready) begin
      vectors++;
      if (exp_r.size() == 0) begin
        miscompares++;
        $display("FAIL r_unexpected: got rdata 0x%0h, expected no response", rdata);
      end else begin
        logic [33:0] e;
        e = exp_r.pop_front();
        if ({rdata, rresp} !== e) begin
          miscompares++;
          $display("FAIL r_data: got 0x%0h/%b, expected 0x%0h/%b",
                   rdata, rresp, e[33:2], e[1:0]);
        end else begin
          $display("ok   r_data: 0x%0h/%b", rdata, rresp);
        end
      end
    end
  end

  // AW and W offered together; returns #1 after the edge completing both.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp);
    bit aw_done, w_done, a_now, w_now;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    exp_b.push_back(resp);
    while (!(aw_done && w_done) && n < 20) begin
      a_now = awvalid && awready;
      w_now = wvalid && wready;
      @(posedge clk); #1;
      if (a_now) begin awvalid = 1'b0; aw_done = 1; end
      if (w_now) begin wvalid = 1'b0; w_done = 1; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      vectors++; miscompares++;
      $display("FAIL wr_timeout: got no AW/W handshake in 20 cycles, expected handshake");
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    bit done, now;
    int n;
    done = 0; n = 0;
    araddr = addr; arvalid = 1'b1;
    exp_r.push_back({data, resp});
    while (!done && n < 20) begin
      now = arready;
      @(posedge clk); #1;
      if (now) begin arvalid = 1'b0; done = 1; end
      n++;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL rd_timeout: got no AR handshake in 20 cycles, expected handshake");
      arvalid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gaps;
    bit now;

    // --- reset state
    #2;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_reg_q_zero", {63'h0, reg_q == '0}, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready", wready, 1);
    @(posedge clk); #1;

    // --- AW+W same cycle
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 2'b00);
    chk("wr_b_latency", bvalid, 1);
    chk_word("wr_word2", 2, 32'hDEADBEEF);
    @(posedge clk); #1;
    do_read(32'h08, 32'hDEADBEEF, 2'b00);
    chk("rd_latency", rvalid, 1);
    @(posedge clk); #1;

    // --- W leads AW by 3 cycles, partial strobe
    do_write(32'h0C, 32'hFFFFFFFF, 4'hF, 2'b00);
    @(posedge clk); #1;
    wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
    now = wready;
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk("wlead_w_accepted", now, 1);
    chk("wlead_wready_low", wready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wlead_no_early_b", bvalid, 0);
    chk_word("wlead_word3_before", 3, 32'hFFFFFFFF);
    awaddr = 32'h0C; awvalid = 1'b1;
    exp_b.push_back(2'b00);
    now = awready;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("wlead_aw_accepted", now, 1);
    chk_word("wlead_word3", 3, 32'hFF22FF44);
    chk("wlead_bvalid", bvalid, 1);
    chk("wlead_wready_back", wready, 1);
    @(posedge clk); #1;

    // --- bready low: second write held until first B completes
    bready = 1'b0;
    do_write(32'h10, 32'hA5A5A5A5, 4'hF, 2'b00);
    do_write(32'h14, 32'h5A5A5A5A, 4'hF, 2'b00);
    chk("bp_awready_low", awready, 0);
    chk("bp_wready_low", wready, 0);
    chk_word("bp_word5_unwritten", 5, 32'h0);
    chk_word("bp_word4", 4, 32'hA5A5A5A5);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_bvalid_stable", {61'h0, bvalid, bresp}, {61'h0, 1'b1, 2'b00});
    end
    bready = 1'b1;
    @(posedge clk); #1;
    chk_word("bp_word5_commit", 5, 32'h5A5A5A5A);
    chk("bp_second_bvalid", bvalid, 1);
    @(posedge clk); #1;
    chk("bp_bvalid_clear", bvalid, 0);

    // --- out-of-range access
    model_q = reg_q;
    model_q = '0;
    model_q[2*DW +: DW] = 32'hDEADBEEF;
    model_q[3*DW +: DW] = 32'hFF22FF44;
    model_q[4*DW +: DW] = 32'hA5A5A5A5;
    model_q[5*DW +: DW] = 32'h5A5A5A5A;
    do_write(32'h40, 32'h12345678, 4'hF, OOR);
    @(posedge clk); #1;
    vectors++;
    if (reg_q !== model_q) begin
      miscompares++;
      $display("FAIL oor_reg_q_unchanged: got %h, expected %h", reg_q, model_q);
    end else begin
      $display("ok   oor_reg_q_unchanged");
    end
    do_read(32'h40, 32'h0, OOR);
    @(posedge clk); #1;

    // --- back-to-back reads of every index
    gaps = 0;
    for (int i = 0; i < RC; i++) begin
      araddr = i * 4; arvalid = 1'b1;
      exp_r.push_back({model_q[i*DW +: DW], 2'b00});
      if (!arready) gaps++;
      @(posedge clk); #1;
      if (!rvalid) gaps++;
    end
    arvalid = 1'b0;
    chk("rd_b2b_gaps", gaps, 0);
    @(posedge clk); #1;

    // --- same-edge write and read of index 3, then read-after-write
    awaddr = 32'h0C; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 32'h0C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    exp_b.push_back(2'b00);
    exp_r.push_back({32'hFF22FF44, 2'b00});
    chk("same_edge_readies", {61'h0, awready, wready, arready}, 64'h7);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk_word("same_edge_word3", 3, 32'hCAFEF00D);
    do_read(32'h0C, 32'hCAFEF00D, 2'b00);
    @(posedge clk); #1;

    // --- reset while a B is pending: response is discarded
    bready = 1'b0;
    awaddr = 32'h18; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("rstmid_bvalid_pending", bvalid, 1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_outputs_zero",
        {57'h0, bvalid, rvalid, awready, wready, arready, bresp},
        64'h0);
    chk("rstmid_reg_q_zero", {63'h0, reg_q == '0}, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    bready = 1'b1;
    #1;
    chk("rstmid_readies_back", {61'h0, awready, wready, arready}, 64'h7);
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_no_stale_b", bvalid, 0);

    // Any response still owed counts against the DUT.
    vectors++;
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      miscompares++;
      $display("FAIL queues_drained: got %0d B and %0d R outstanding, expected 0 and 0",
               exp_b.size(), exp_r.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
